// File: rtl/eu_tag_arbiter_if.sv
// eu_tag_arbiter_if: EU completion handshake plus the registered dispatcher completion port
interface eu_tag_arbiter_if #(
    parameter int NumEus   = 4,
    parameter int TagWidth = 3
);
    logic [NumEus-1:0]                eu_valid_i;
    logic [NumEus-1:0][TagWidth-1:0]  eu_tag_i;
    logic [NumEus-1:0]                eu_ready_o;
    logic                             disp_valid_o;
    logic [TagWidth-1:0]              disp_tag_o;
    modport master (output eu_valid_i, eu_tag_i, input eu_ready_o, disp_valid_o, disp_tag_o);
    modport slave  (input eu_valid_i, eu_tag_i, output eu_ready_o, disp_valid_o, disp_tag_o);
endinterface

// File: rtl/eu_tag_arbiter.sv
// eu_tag_arbiter: per-EU completion FIFOs, round-robin merge onto the dispatcher port, in-flight tag tracking
module eu_tag_arbiter #(
    parameter int NumTags   = 8,
    parameter int NumEus    = 4,
    parameter int FifoDepth = 2,
    parameter int TagWidth  = $clog2(NumTags),
    parameter int CntWidth  = $clog2(NumTags + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_valid_i,
    input  logic [TagWidth-1:0] alloc_tag_i,
    eu_tag_arbiter_if.slave     bus,
    output logic [CntWidth-1:0] inflight_cnt_o,
    output logic                idle_o,
    output logic                error_o
);
    localparam int EuW  = NumEus > 1 ? $clog2(NumEus) : 1;
    localparam int PtrW = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
    localparam int OccW = $clog2(FifoDepth + 1);

    logic [NumEus-1:0][FifoDepth-1:0][TagWidth-1:0] mem_q;
    logic [NumEus-1:0][PtrW-1:0] wr_q, rd_q;
    logic [NumEus-1:0][OccW-1:0] occ_q;
    logic [NumEus-1:0] empty, full, push, pop;
    logic [EuW-1:0] rr_q, gnt;
    logic gnt_valid;
    logic [TagWidth-1:0] head;
    logic [NumTags-1:0] inflight_q, set_vec, clr_vec, inflight_d;
    logic [CntWidth-1:0] cnt_d;
    logic err_d;
    logic disp_valid_q;
    logic [TagWidth-1:0] disp_tag_q;

    always_comb begin
        for (int i = 0; i < NumEus; i++) begin
            empty[i] = occ_q[i] == '0;
            full[i]  = occ_q[i] == OccW'(FifoDepth);
            push[i]  = bus.eu_valid_i[i] && !full[i];
            pop[i]   = gnt_valid && gnt == EuW'(i);
        end
    end

    // Scan farthest-first so the nearest non-empty FIFO after rr_q overwrites earlier hits
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        for (int k = NumEus - 1; k >= 0; k--) begin
            if (!empty[(int'(rr_q) + k) % NumEus]) begin
                gnt_valid = 1'b1;
                gnt       = EuW'((int'(rr_q) + k) % NumEus);
            end
        end
    end

    assign head = mem_q[gnt][rd_q[gnt]];

    always_comb begin
        set_vec    = alloc_valid_i ? NumTags'(1) << alloc_tag_i : '0;
        clr_vec    = gnt_valid ? NumTags'(1) << head : '0;
        inflight_d = (inflight_q & ~clr_vec) | set_vec;
        cnt_d      = '0;
        for (int t = 0; t < NumTags; t++) cnt_d = cnt_d + CntWidth'(inflight_d[t]);
        err_d = error_o
              | (|(bus.eu_valid_i & full))
              | (gnt_valid && !inflight_q[head])
              | (alloc_valid_i && inflight_q[alloc_tag_i] && !clr_vec[alloc_tag_i]);
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumEus; i++)
            if (push[i]) mem_q[i][wr_q[i]] <= bus.eu_tag_i[i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q           <= '0;
            rd_q           <= '0;
            occ_q          <= '0;
            rr_q           <= '0;
            disp_valid_q   <= 1'b0;
            disp_tag_q     <= '0;
            inflight_q     <= '0;
            inflight_cnt_o <= '0;
            error_o        <= 1'b0;
        end else begin
            for (int i = 0; i < NumEus; i++) begin
                if (push[i]) wr_q[i] <= wr_q[i] == PtrW'(FifoDepth - 1) ? '0 : wr_q[i] + 1'b1;
                if (pop[i]) rd_q[i] <= rd_q[i] == PtrW'(FifoDepth - 1) ? '0 : rd_q[i] + 1'b1;
                occ_q[i] <= occ_q[i] + OccW'(push[i]) - OccW'(pop[i]);
            end
            rr_q           <= gnt_valid ? (gnt == EuW'(NumEus - 1) ? '0 : gnt + 1'b1) : rr_q;
            disp_valid_q   <= gnt_valid;
            disp_tag_q     <= gnt_valid ? head : disp_tag_q;
            inflight_q     <= inflight_d;
            inflight_cnt_o <= cnt_d;
            error_o        <= err_d;
        end
    end

    assign bus.eu_ready_o   = ~full;
    assign bus.disp_valid_o = disp_valid_q;
    assign bus.disp_tag_o   = disp_tag_q;
    assign idle_o           = &empty && !disp_valid_q;
endmodule

// File: tb/tb_eu_tag_arbiter.sv
// tb_eu_tag_arbiter: directed and random stimulus checked against a queue-based reference model
module tb_eu_tag_arbiter;
    localparam int NT = 8;
    localparam int NE = 4;
    localparam int FD = 2;
    localparam int TW = 3;
    localparam int CW = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic alloc_valid_i;
    logic [TW-1:0] alloc_tag_i;
    logic [CW-1:0] inflight_cnt_o;
    logic idle_o;
    logic error_o;

    eu_tag_arbiter_if #(.NumEus(NE), .TagWidth(TW)) bus ();

    eu_tag_arbiter #(.NumTags(NT), .NumEus(NE), .FifoDepth(FD)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_tag_i    (alloc_tag_i),
        .bus            (bus),
        .inflight_cnt_o (inflight_cnt_o),
        .idle_o         (idle_o),
        .error_o        (error_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    // Reference model: FIFOs as queues, in-flight set as a bit array
    int q[NE][$];
    int pend[$];
    int rr;
    bit infl[NT];
    bit m_dv;
    int m_dt;
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic check_all();
        int c = 0;
        bit all_empty = 1;
        logic [NE-1:0] rdy;
        for (int t = 0; t < NT; t++) c += int'(infl[t]);
        for (int i = 0; i < NE; i++) begin
            rdy[i] = q[i].size() < FD;
            if (q[i].size() != 0) all_empty = 0;
        end
        chk("disp_valid", 32'(bus.disp_valid_o), 32'(m_dv));
        chk("disp_tag", 32'(bus.disp_tag_o), m_dt);
        chk("eu_ready", 32'(bus.eu_ready_o), 32'(rdy));
        chk("inflight_cnt", 32'(inflight_cnt_o), c);
        chk("idle", 32'(idle_o), 32'(all_empty && !m_dv));
        chk("error", 32'(error_o), 32'(m_err));
    endtask

    task automatic model_step();
        int g = -1;
        int gt = -1;
        bit rdy[NE];
        if (rst_i) begin
            for (int i = 0; i < NE; i++) q[i].delete();
            pend.delete();
            for (int t = 0; t < NT; t++) infl[t] = 0;
            rr = 0;
            m_dv = 0;
            m_dt = 0;
            m_err = 0;
            return;
        end
        for (int i = 0; i < NE; i++) rdy[i] = q[i].size() < FD;
        for (int k = 0; k < NE; k++)
            if (g < 0 && q[(rr + k) % NE].size() != 0) g = (rr + k) % NE;
        if (g >= 0) begin
            gt = q[g].pop_front();
            rr = (g + 1) % NE;
            if (!infl[gt]) m_err = 1;
        end
        for (int i = 0; i < NE; i++)
            if (bus.eu_valid_i[i]) begin
                if (rdy[i]) q[i].push_back(int'(bus.eu_tag_i[i]));
                else m_err = 1;
            end
        if (alloc_valid_i && infl[alloc_tag_i] && gt != int'(alloc_tag_i)) m_err = 1;
        if (gt >= 0) infl[gt] = 0;
        if (alloc_valid_i) infl[alloc_tag_i] = 1;
        m_dv = g >= 0;
        if (g >= 0) m_dt = gt;
    endtask

    task automatic tick();
        check_all();
        model_step();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        alloc_valid_i = 0;
        bus.eu_valid_i = '0;
    endtask

    // Legal traffic: allocate free tags, hand allocated tags to ready EUs in the mask
    task automatic drive_cycle(input logic [NE-1:0] mask, input int push_pct, input int alloc_pct);
        int fr[$];
        for (int t = 0; t < NT; t++) if (!infl[t]) fr.push_back(t);
        for (int i = NE - 1; i >= 0; i--)
            if (mask[i] && q[i].size() < FD && pend.size() > 0 && int'($urandom_range(0, 99)) < push_pct) begin
                int k = int'($urandom_range(0, pend.size() - 1));
                bus.eu_valid_i[i] = 1'b1;
                bus.eu_tag_i[i] = TW'(pend[k]);
                pend.delete(k);
            end
        if (fr.size() > 0 && int'($urandom_range(0, 99)) < alloc_pct) begin
            int k = int'($urandom_range(0, fr.size() - 1));
            alloc_valid_i = 1'b1;
            alloc_tag_i = TW'(fr[k]);
            pend.push_back(fr[k]);
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1;
        alloc_valid_i = 0;
        alloc_tag_i = '0;
        bus.eu_valid_i = '0;
        bus.eu_tag_i = '0;
        model_step();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        // Single tag latency through EU0
        alloc_valid_i = 1; alloc_tag_i = 3; tick();
        bus.eu_valid_i[0] = 1; bus.eu_tag_i[0] = 3; tick();
        repeat (4) tick();
        // All four EUs push in one cycle from rr_q = 0
        rst_i = 1; tick();
        for (int t = 0; t < 4; t++) begin
            alloc_valid_i = 1; alloc_tag_i = TW'(t); tick();
        end
        bus.eu_valid_i = '1;
        for (int i = 0; i < NE; i++) bus.eu_tag_i[i] = TW'(i);
        tick();
        repeat (6) tick();
        chk("rr_end", 32'(dut.rr_q), rr);
        // EU1 and EU2 streaming
        repeat (4) drive_cycle('0, 0, 100);
        repeat (100) drive_cycle(4'b0110, 100, 100);
        repeat (8) drive_cycle('0, 0, 0);
        // Set wins over clear on the grant cycle, then a true double allocation
        rst_i = 1; tick();
        alloc_valid_i = 1; alloc_tag_i = 5; tick();
        bus.eu_valid_i[0] = 1; bus.eu_tag_i[0] = 5; tick();
        alloc_valid_i = 1; alloc_tag_i = 5; tick();
        repeat (2) tick();
        alloc_valid_i = 1; alloc_tag_i = 5; tick();
        repeat (3) tick();
        // Valid into a full FIFO on EU2
        rst_i = 1; tick();
        repeat (8) drive_cycle('0, 0, 100);
        for (int n = 0; n < 20 && q[2].size() < FD; n++) drive_cycle(4'b0111, 100, 100);
        chk("eu2_full", 32'(bus.eu_ready_o[2]), 0);
        bus.eu_valid_i[2] = 1; bus.eu_tag_i[2] = 6; tick();
        repeat (10) drive_cycle('0, 0, 0);
        // Reset with every FIFO holding tags
        rst_i = 1; tick();
        repeat (8) drive_cycle('0, 0, 100);
        repeat (3) drive_cycle(4'hF, 100, 0);
        rst_i = 1; tick();
        repeat (6) tick();
        // Random legal traffic
        repeat (400) drive_cycle(4'hF, 60, 70);
        repeat (10) drive_cycle('0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
